// File: rtl/test_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// test_pattern_gen : frame-synchronous multi-mode RGB test pattern generator
// Revision 1.0
// ---------------------------------------------------------------------------
module test_pattern_gen #(
  parameter int          H_PIXEL    = 1280,
  parameter int          V_PIXEL    = 720,
  parameter int          ADDR_W     = 21,
  parameter int          COLOR_W    = 8,
  parameter int          CHECK_LOG2 = 5,
  parameter int          BAR_SPEED  = 4,
  parameter int          BAR_WIDTH  = 16,
  parameter logic [23:0] SOLID_RGB  = 24'hFF0000
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [2:0]         mode,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_start,
  output logic [10:0]        pix_x,
  output logic [9:0]         pix_y
);

  localparam logic [10:0] X_LAST   = 11'(H_PIXEL - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_PIXEL - 1);
  localparam logic [9:0]  Y_HALF   = 10'(V_PIXEL / 2);
  localparam int          BAR_W    = H_PIXEL / 8;
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
  localparam int          GRAD_Q   = (1 << COLOR_W) / H_PIXEL;
  localparam int          GRAD_R   = (1 << COLOR_W) % H_PIXEL;

  localparam logic [2:0] MODE_SOLID = 3'd0;
  localparam logic [2:0] MODE_SPLIT = 3'd1;
  localparam logic [2:0] MODE_BARS  = 3'd2;
  localparam logic [2:0] MODE_CHECK = 3'd3;
  localparam logic [2:0] MODE_GRAD  = 3'd4;
  localparam logic [2:0] MODE_MOVE  = 3'd5;

  localparam logic [COLOR_W-1:0] FULL = '1;

  logic [ADDR_W-1:0]  addr_prev;
  logic               advance;
  logic               frame_evt;
  logic [2:0]         active_mode;
  logic [10:0]        bar_pos;
  logic [11:0]        bar_sum;
  logic [10:0]        bar_pos_next;
  logic               started;
  logic [10:0]        x;
  logic [9:0]         y;
  logic [10:0]        bar_cnt;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] grey;
  logic [11:0]        grey_rem;
  logic [11:0]        rem_sum;
  logic [11:0]        rem_next;
  logic [COLOR_W-1:0] grey_step;
  logic               pix0;
  logic [11:0]        bar_diff;
  logic [2:0]         bar_rgb;
  logic [COLOR_W-1:0] nxt_r;
  logic [COLOR_W-1:0] nxt_g;
  logic [COLOR_W-1:0] nxt_b;

  // Any change of addr is one pixel step; only a step onto 0 opens a frame.
  assign advance   = (addr != addr_prev);
  assign frame_evt = advance && (addr == '0);

  assign bar_sum      = {1'b0, bar_pos} + 12'(BAR_SPEED);
  assign bar_pos_next = (bar_sum >= 12'(H_PIXEL)) ? 11'(bar_sum - 12'(H_PIXEL))
                                                  : bar_sum[10:0];

  // Gradient DDA: add 2^COLOR_W/H_PIXEL per pixel, carrying the remainder.
  assign rem_sum   = grey_rem + 12'(GRAD_R);
  assign rem_next  = (rem_sum >= 12'(H_PIXEL)) ? (rem_sum - 12'(H_PIXEL)) : rem_sum;
  assign grey_step = (rem_sum >= 12'(H_PIXEL)) ? COLOR_W'(GRAD_Q + 1) : COLOR_W'(GRAD_Q);

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      addr_prev   <= '1;
      active_mode <= MODE_SOLID;
      bar_pos     <= '0;
      started     <= 1'b0;
      x           <= '0;
      y           <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      grey        <= '0;
      grey_rem    <= '0;
      pix0        <= 1'b0;
    end else begin
      addr_prev <= addr;
      pix0      <= frame_evt;
      if (frame_evt) begin
        x           <= '0;
        y           <= '0;
        active_mode <= mode;
        bar_pos     <= bar_pos_next;
        started     <= 1'b1;
        bar_cnt     <= '0;
        bar_idx     <= '0;
        grey        <= '0;
        grey_rem    <= '0;
      end else if (advance) begin
        if (x == X_LAST) begin
          x        <= '0;
          if (y != Y_LAST) y <= y + 10'd1;
          bar_cnt  <= '0;
          bar_idx  <= '0;
          grey     <= '0;
          grey_rem <= '0;
        end else begin
          x        <= x + 11'd1;
          grey     <= grey + grey_step;
          grey_rem <= rem_next;
          // Leftover pixels after bar 6 stay in bar 7.
          if (bar_idx != 3'd7) begin
            if (bar_cnt == BAR_LAST) begin
              bar_cnt <= '0;
              bar_idx <= bar_idx + 3'd1;
            end else begin
              bar_cnt <= bar_cnt + 11'd1;
            end
          end
        end
      end
    end
  end

  assign bar_diff = (x >= bar_pos) ? ({1'b0, x} - {1'b0, bar_pos})
                                   : ({1'b0, x} + 12'(H_PIXEL) - {1'b0, bar_pos});

  always_comb begin
    bar_rgb = 3'b000;
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    nxt_r = '0;
    nxt_g = '0;
    nxt_b = '0;
    if (started) begin
      case (active_mode)
        MODE_SOLID: begin
          nxt_r = SOLID_RGB[23 -: COLOR_W];
          nxt_g = SOLID_RGB[15 -: COLOR_W];
          nxt_b = SOLID_RGB[7  -: COLOR_W];
        end
        MODE_SPLIT: begin
          if (y < Y_HALF) nxt_r = FULL;
          else            nxt_b = FULL;
        end
        MODE_BARS: begin
          nxt_r = {COLOR_W{bar_rgb[2]}};
          nxt_g = {COLOR_W{bar_rgb[1]}};
          nxt_b = {COLOR_W{bar_rgb[0]}};
        end
        MODE_CHECK: begin
          nxt_r = {COLOR_W{x[CHECK_LOG2] ^ y[CHECK_LOG2]}};
          nxt_g = {COLOR_W{x[CHECK_LOG2] ^ y[CHECK_LOG2]}};
          nxt_b = {COLOR_W{x[CHECK_LOG2] ^ y[CHECK_LOG2]}};
        end
        MODE_GRAD: begin
          nxt_r = grey;
          nxt_g = grey;
          nxt_b = grey;
        end
        MODE_MOVE: begin
          nxt_r = {COLOR_W{bar_diff < 12'(BAR_WIDTH)}};
          nxt_g = {COLOR_W{bar_diff < 12'(BAR_WIDTH)}};
          nxt_b = {COLOR_W{bar_diff < 12'(BAR_WIDTH)}};
        end
        default: begin
          nxt_r = '0;
          nxt_g = '0;
          nxt_b = '0;
        end
      endcase
    end
  end

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      red         <= nxt_r;
      green       <= nxt_g;
      blue        <= nxt_b;
      frame_start <= pix0;
      pix_x       <= x;
      pix_y       <= y;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_gen.sv
`default_nettype none
// Bench for test_pattern_gen: scoreboarded frame sweeps plus a spot-check vector table.
module tb_test_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;

  logic        clk;
  logic        reset;
  logic [5:0]  addr;
  logic [2:0]  mode;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  test_pattern_gen #(
    .H_PIXEL(H), .V_PIXEL(V), .ADDR_W(6), .COLOR_W(8), .CHECK_LOG2(1),
    .BAR_SPEED(4), .BAR_WIDTH(4), .SOLID_RGB(24'hFF0000)
  ) dut (
    .pixclk(clk), .reset(reset), .addr(addr), .mode(mode),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        fs;
    logic        chk_xy;
    int          px;
    int          py;
    int          frame;
    int          addr;
  } sb_t;

  typedef struct {
    int          frame;
    int          addr;
    logic [23:0] rgb;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[$];
  logic [23:0] got [0:9][0:63];
  int          cyc;
  int          checks;
  int          errors;
  int          fs_pulses;
  int          model_bar;
  logic        model_started;

  function automatic logic [23:0] model_rgb(input logic [2:0] m, input int x, input int y,
                                            input int bar);
    int idx;
    int g;
    int d;
    idx = x / 2;
    if (idx > 7) idx = 7;
    g = (x * 256) / H;
    d = (x - bar + H) % H;
    case (m)
      3'd0: return 24'hFF0000;
      3'd1: return (y < V / 2) ? 24'hFF0000 : 24'h0000FF;
      3'd2: begin
        case (idx)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      3'd3: return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3'd4: return {g[7:0], g[7:0], g[7:0]};
      3'd5: return (d < 4) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic push(input int due, input logic [23:0] rgb, input logic fs, input logic chk_xy,
                      input int px, input int py, input int frame, input int a);
    sb_t e;
    e.due = due; e.rgb = rgb; e.fs = fs; e.chk_xy = chk_xy;
    e.px = px; e.py = py; e.frame = frame; e.addr = a;
    sb.push_back(e);
  endtask

  task automatic check_now;
    sb_t  e;
    logic ok;
    if (frame_start === 1'b1) fs_pulses++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due < cyc) begin
        errors++;
        $display("FAIL late_entry frame %0d addr %0d due %0d now %0d", e.frame, e.addr, e.due, cyc);
      end else begin
        ok = ({red, green, blue} === e.rgb) && (frame_start === e.fs) &&
             (!e.chk_xy || ((pix_x === 11'(e.px)) && (pix_y === 10'(e.py))));
        if (e.frame >= 0) got[e.frame][e.addr] = {red, green, blue};
        if (!ok) begin
          errors++;
          $display("FAIL pixel frame %0d addr %0d: got rgb %h fs %b xy %0d,%0d; want rgb %h fs %b xy %0d,%0d",
                   e.frame, e.addr, {red, green, blue}, frame_start, pix_x, pix_y,
                   e.rgb, e.fs, e.px, e.py);
        end
      end
    end
  endtask

  task automatic tick;
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  // One full frame, two blanking cycles after each line; optional mid-frame mode poke / reset.
  task automatic run_frame(input logic [2:0] m, input int fid, input int sw_at,
                           input logic [2:0] sw_mode, input int rst_at);
    logic [2:0]  fm;
    logic [23:0] e_rgb;
    logic        xy_ok;
    int          x;
    int          y;
    fm    = m;
    xy_ok = 1'b1;
    mode  = m;
    for (int a = 0; a < H * V; a++) begin
      x = a % H;
      y = a / H;
      if (a == sw_at) mode = sw_mode;
      addr = 6'(a);
      if (a == 0) begin
        fm            = m;
        model_bar     = (model_bar + 4) % H;
        model_started = 1'b1;
      end
      if (a == rst_at) begin
        reset = 1'b0;
        #1;
        checks++;
        if ({red, green, blue} !== 24'h0) begin
          errors++;
          $display("FAIL async_reset rgb %h want 000000", {red, green, blue});
        end
        foreach (sb[i]) begin
          sb[i].rgb = 24'h0; sb[i].fs = 1'b0; sb[i].chk_xy = 1'b0;
        end
        model_started = 1'b0;
        model_bar     = 0;
        xy_ok         = 1'b0;
      end
      e_rgb = model_started ? model_rgb(fm, x, y, model_bar) : 24'h0;
      push(cyc + 2, e_rgb, (a == 0), xy_ok, x, y, fid, a);
      tick();
      if (a == rst_at) reset = 1'b1;
      if (x == H - 1) begin
        for (int b = 0; b < 2; b++) begin
          push(cyc + 2, e_rgb, 1'b0, xy_ok, x, y, fid, a);
          tick();
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{0, 0, 24'hFF0000}, '{0, 31, 24'hFF0000}, '{0, 32, 24'h0000FF}, '{0, 63, 24'h0000FF},
      '{1, 0, 24'hFFFFFF}, '{1, 1, 24'hFFFFFF}, '{1, 2, 24'hFFFF00}, '{1, 3, 24'hFFFF00},
      '{1, 14, 24'h000000}, '{1, 15, 24'h000000},
      '{2, 0, 24'h000000}, '{2, 8, 24'h808080}, '{2, 15, 24'hF0F0F0},
      '{3, 4, 24'hFFFFFF}, '{3, 7, 24'hFFFFFF}, '{3, 3, 24'h000000}, '{3, 8, 24'h000000},
      '{4, 8, 24'hFFFFFF}, '{4, 11, 24'hFFFFFF}, '{4, 12, 24'h000000},
      '{5, 12, 24'hFFFFFF}, '{5, 15, 24'hFFFFFF}, '{5, 11, 24'h000000},
      '{6, 0, 24'hFFFFFF}, '{6, 3, 24'hFFFFFF}, '{6, 4, 24'h000000},
      '{7, 20, 24'hFF0000}, '{7, 63, 24'hFF0000},
      '{8, 2, 24'hFFFFFF}, '{8, 0, 24'h000000}, '{8, 40, 24'h000000}, '{8, 63, 24'h000000},
      '{9, 2, 24'hFFFFFF}, '{9, 0, 24'h000000}, '{9, 18, 24'hFFFFFF}, '{9, 34, 24'h000000}
    };
    for (int f = 0; f < 10; f++)
      for (int a = 0; a < 64; a++) got[f][a] = 24'h123456;

    checks = 0; errors = 0; cyc = 0; fs_pulses = 0;
    model_bar = 0; model_started = 1'b0;
    reset = 1'b0; addr = 6'd5; mode = 3'd0;
    @(posedge clk);
    #1;
    tick();
    tick();
    checks++;
    if ({red, green, blue, frame_start, pix_x, pix_y} !== '0) begin
      errors++;
      $display("FAIL reset_state rgb %h fs %b xy %0d,%0d want all zero",
               {red, green, blue}, frame_start, pix_x, pix_y);
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(cyc, 24'h0, 1'b0, 1'b0, 0, 0, -1, 5);
      tick();
    end

    fs_pulses = 0;
    run_frame(3'd1, 0, -1, 3'd0, -1);
    drain();
    checks++;
    if (fs_pulses != 1) begin
      errors++;
      $display("FAIL frame_start_count got %0d want 1", fs_pulses);
    end
    run_frame(3'd2, 1, -1, 3'd0, -1);
    run_frame(3'd4, 2, -1, 3'd0, -1);
    drain();

    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_bar = 0;
    model_started = 1'b0;
    for (int f = 3; f < 7; f++) run_frame(3'd5, f, -1, 3'd0, -1);

    run_frame(3'd0, 7, 20, 3'd3, -1);
    run_frame(3'd3, 8, -1, 3'd0, 40);
    run_frame(3'd3, 9, -1, 3'd0, -1);
    drain();

    for (int i = 0; i < vecs.size(); i++) begin
      checks++;
      if (got[vecs[i].frame][vecs[i].addr] !== vecs[i].rgb) begin
        errors++;
        $display("FAIL vec%0d frame %0d addr %0d got %h want %h", i, vecs[i].frame,
                 vecs[i].addr, got[vecs[i].frame][vecs[i].addr], vecs[i].rgb);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
